// File: rtl/bus_switch_scheduler_if.sv
// ---------------------------------------------------------------------------
// bus_switch_scheduler_if : requester, command and release signals of the
// busSwitch command scheduler.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bus_switch_scheduler_if #(
  parameter int N = 4,
  parameter int R = 2
);
  logic [R*2*N-1:0] req_cmd;
  logic [R-1:0]     req_isReady;
  logic [R-1:0]     req_canReceive;
  logic [N*N-1:0]   allowedCMDMask;
  logic [2*N-1:0]   cmd;
  logic             cmd_isReady;
  logic             cmd_canReceive;
  logic [N-1:0]     done_isLast;
  logic [N-1:0]     busy;
  logic             err;
  logic [R-1:0]     err_req;

  modport slave (
    input  req_cmd, req_isReady, allowedCMDMask, cmd_canReceive, done_isLast,
    output req_canReceive, cmd, cmd_isReady, busy, err, err_req
  );

  modport master (
    output req_cmd, req_isReady, allowedCMDMask, cmd_canReceive, done_isLast,
    input  req_canReceive, cmd, cmd_isReady, busy, err, err_req
  );
endinterface

`default_nettype wire

// File: rtl/bus_switch_scheduler.sv
// ---------------------------------------------------------------------------
// bus_switch_scheduler : round-robin issue of conflict-free routes to
// busSwitch, with endpoint occupancy tracking.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_switch_scheduler #(
  parameter int N = 4,
  parameter int R = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  bus_switch_scheduler_if.slave  bus
);

  localparam int             c_cmd_w = 2 * N;
  localparam int             c_sel_w = (R > 1) ? $clog2(R) : 1;
  localparam int             c_try_w = c_sel_w + 1;
  localparam logic [N-1:0]   c_one_n = N'(1);

  logic [N-1:0]         r_busy;
  logic [N-1:0]         r_route [N];
  logic [c_cmd_w-1:0]   r_cmd;
  logic                 r_cmd_vld;
  logic [c_sel_w-1:0]   r_ptr;
  logic                 r_err;
  logic [R-1:0]         r_err_req;

  logic [N-1:0]         w_src   [R];
  logic [N-1:0]         w_dst   [R];
  logic [N-1:0]         w_allow [R];
  logic [R-1:0]         w_mal;
  logic [R-1:0]         w_cand;
  logic                 w_found;
  logic [c_sel_w-1:0]   w_sel;
  logic [c_try_w-1:0]   w_try;
  logic                 w_slot_free;
  logic                 w_consume;
  logic                 w_grant;
  logic [R-1:0]         w_take;
  logic [c_cmd_w-1:0]   w_sel_cmd;
  logic [N-1:0]         w_grant_mask;
  logic [N-1:0]         w_rel;
  logic [N-1:0]         w_rel_mask;
  logic [c_sel_w-1:0]   w_ptr_nxt;

  // Decode each request; a source that is not one-hot is malformed, so the
  // allowed-destination OR over all set source bits is exact when it matters.
  always_comb begin
    for (int r = 0; r < R; r++) begin
      w_src[r]   = bus.req_cmd[r*c_cmd_w +: N];
      w_dst[r]   = bus.req_cmd[r*c_cmd_w + N +: N];
      w_allow[r] = '0;
      for (int d = 0; d < N; d++) begin
        for (int s = 0; s < N; s++) begin
          if (w_src[r][s] && bus.allowedCMDMask[d*N + s]) begin
            w_allow[r][d] = 1'b1;
          end
        end
      end
      w_mal[r]  = (w_src[r] == '0)
               || ((w_src[r] & (w_src[r] - c_one_n)) != '0)
               || (w_dst[r] == '0)
               || ((w_src[r] & w_dst[r]) != '0)
               || ((w_dst[r] & ~w_allow[r]) != '0);
      w_cand[r] = bus.req_isReady[r]
               && (w_mal[r] || (((w_src[r] | w_dst[r]) & r_busy) == '0));
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_try   = '0;
    for (int k = 0; k < R; k++) begin
      w_try = {1'b0, r_ptr} + c_try_w'(k);
      if (w_try >= c_try_w'(R)) begin
        w_try = w_try - c_try_w'(R);
      end
      if (!w_found && w_cand[w_try[c_sel_w-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_try[c_sel_w-1:0];
      end
    end
  end

  assign w_slot_free  = !r_cmd_vld || bus.cmd_canReceive;
  assign w_consume    = !rst && w_slot_free && w_found;
  assign w_grant      = w_consume && !w_mal[w_sel];
  assign w_sel_cmd    = bus.req_cmd[w_sel*c_cmd_w +: c_cmd_w];
  assign w_grant_mask = w_grant ? (w_src[w_sel] | w_dst[w_sel]) : '0;
  assign w_ptr_nxt    = (w_sel == c_sel_w'(R - 1)) ? '0 : w_sel + c_sel_w'(1);
  assign w_rel        = bus.done_isLast & r_busy;

  always_comb begin
    w_take = '0;
    for (int r = 0; r < R; r++) begin
      w_take[r] = w_consume && (w_sel == c_sel_w'(r));
    end
  end

  // A release frees its own endpoint plus every endpoint its route claimed.
  always_comb begin
    w_rel_mask = w_rel;
    for (int s = 0; s < N; s++) begin
      if (w_rel[s]) begin
        w_rel_mask = w_rel_mask | r_route[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd     <= '0;
      r_cmd_vld <= 1'b0;
      r_busy    <= '0;
      r_ptr     <= '0;
      r_err     <= 1'b0;
      r_err_req <= '0;
      for (int s = 0; s < N; s++) begin
        r_route[s] <= '0;
      end
    end else begin
      r_err     <= w_consume && w_mal[w_sel];
      r_err_req <= w_take & {R{w_mal[w_sel]}};
      if (w_grant) begin
        r_cmd     <= w_sel_cmd;
        r_cmd_vld <= 1'b1;
      end else if (r_cmd_vld && bus.cmd_canReceive) begin
        r_cmd     <= '0;
        r_cmd_vld <= 1'b0;
      end
      // Granted bits are never busy, so grant and release never collide.
      r_busy <= (r_busy & ~w_rel_mask) | w_grant_mask;
      for (int s = 0; s < N; s++) begin
        if (w_rel[s]) begin
          r_route[s] <= '0;
        end else if (w_grant && w_src[w_sel][s]) begin
          r_route[s] <= w_dst[w_sel];
        end
      end
      if (w_consume) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign bus.req_canReceive = w_take;
  assign bus.cmd            = r_cmd;
  assign bus.cmd_isReady    = r_cmd_vld;
  assign bus.busy           = r_busy;
  assign bus.err            = r_err;
  assign bus.err_req        = r_err_req;

endmodule

`default_nettype wire

// File: tb/tb_bus_switch_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bus_switch_scheduler : directed plus randomized bench against an
// endpoint-ownership reference model.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bus_switch_scheduler;

  localparam int N = 4;
  localparam int R = 2;
  localparam int CW = 2 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_switch_scheduler_if #(.N(N), .R(R)) bus ();

  bus_switch_scheduler #(.N(N), .R(R)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus state
  bit [CW-1:0]  rq [R];
  bit           rv [R];
  bit [N*N-1:0] allow;
  bit           ccr;
  bit [N-1:0]   done;
  bit [R-1:0]   last_taken;

  // Reference model: endpoint occupancy, per-source route, pending output slot
  bit [N-1:0]   m_busy;
  bit [N-1:0]   m_route [N];
  bit           m_vld;
  bit [CW-1:0]  m_cmd;
  int           m_ptr;
  bit           m_err;
  bit [R-1:0]   m_err_req;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input bit [CW-1:0] c, input bit [N*N-1:0] a);
    bit [N-1:0] s;
    bit [N-1:0] d;
    int ones;
    int si;
    s = c[N-1:0];
    d = c[CW-1:N];
    ones = 0;
    si = 0;
    for (int i = 0; i < N; i++) begin
      if (s[i]) begin
        ones++;
        si = i;
      end
    end
    if (ones != 1 || d == 0 || (s & d) != 0) return 1'b1;
    for (int i = 0; i < N; i++) begin
      if (d[i] && !a[i*N + si]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit [CW-1:0] rand_req();
    bit [N-1:0] s;
    bit [N-1:0] d;
    int si;
    if ($urandom_range(0, 9) == 0) return CW'($urandom);
    si = $urandom_range(0, N - 1);
    s = '0;
    s[si] = 1'b1;
    d = N'($urandom_range(1, (1 << N) - 1));
    d[si] = 1'b0;
    if (d == 0) d[(si + 1) % N] = 1'b1;
    return {d, s};
  endfunction

  task automatic drive();
    for (int r = 0; r < R; r++) begin
      bus.req_cmd[r*CW +: CW] = rq[r];
      bus.req_isReady[r]      = rv[r];
    end
    bus.allowedCMDMask = allow;
    bus.cmd_canReceive = ccr;
    bus.done_isLast    = done;
  endtask

  task automatic model_step(input int pick);
    bit [N-1:0] old_busy;
    bit [N-1:0] s;
    bit [N-1:0] d;
    if (rst) begin
      m_busy = '0;
      m_vld = 1'b0;
      m_cmd = '0;
      m_ptr = 0;
      m_err = 1'b0;
      m_err_req = '0;
      for (int i = 0; i < N; i++) m_route[i] = '0;
      return;
    end
    old_busy = m_busy;
    m_err = 1'b0;
    m_err_req = '0;
    for (int i = 0; i < N; i++) begin
      if (done[i] && old_busy[i]) begin
        m_busy[i] = 1'b0;
        m_busy = m_busy & ~m_route[i];
        m_route[i] = '0;
      end
    end
    if (m_vld && ccr) begin
      m_vld = 1'b0;
      m_cmd = '0;
    end
    if (pick >= 0) begin
      if (is_bad(rq[pick], allow)) begin
        m_err = 1'b1;
        m_err_req[pick] = 1'b1;
      end else begin
        s = rq[pick][N-1:0];
        d = rq[pick][CW-1:N];
        m_vld = 1'b1;
        m_cmd = rq[pick];
        m_busy = m_busy | s | d;
        for (int i = 0; i < N; i++) if (s[i]) m_route[i] = d;
      end
      m_ptr = (pick + 1) % R;
    end
  endtask

  // One clock: check registered state, predict and check consumption, advance model.
  task automatic cycle();
    bit [R-1:0] exp_rc;
    int pick;
    int r;
    bit [N-1:0] ep;
    drive();
    @(negedge clk);
    check("busy", bus.busy, m_busy);
    check("cmd_isReady", bus.cmd_isReady, m_vld);
    check("cmd", bus.cmd, m_cmd);
    check("err", bus.err, m_err);
    check("err_req", bus.err_req, m_err_req);
    pick = -1;
    if (!rst && (!m_vld || ccr)) begin
      for (int k = 0; k < R; k++) begin
        r = (m_ptr + k) % R;
        ep = rq[r][N-1:0] | rq[r][CW-1:N];
        if (pick < 0 && rv[r] && (is_bad(rq[r], allow) || (ep & m_busy) == 0)) pick = r;
      end
    end
    exp_rc = '0;
    if (pick >= 0) exp_rc[pick] = 1'b1;
    check("req_canReceive", bus.req_canReceive, exp_rc);
    model_step(pick);
    last_taken = exp_rc;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_taken();
    for (int r = 0; r < R; r++) if (last_taken[r]) rv[r] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    done = '0;
    for (int r = 0; r < R; r++) rv[r] = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    allow = '1;
    ccr = 1'b1;
    done = '0;
    for (int r = 0; r < R; r++) begin
      rq[r] = '0;
      rv[r] = 1'b0;
    end
    for (int i = 0; i < N; i++) m_route[i] = '0;
    m_busy = '0; m_vld = 1'b0; m_cmd = '0; m_ptr = 0; m_err = 1'b0; m_err_req = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single grant: 0 -> 1
    rq[0] = 8'h21; rv[0] = 1'b1;
    cycle(); drop_taken();
    check("tp_cmd", bus.cmd, 8'h21);
    check("tp_busy", bus.busy, 4'b0011);

    // Conflict on endpoint 1, then release from source 0
    rq[1] = 8'h42; rv[1] = 1'b1;
    cycle(); cycle();
    check("tp_stall", bus.busy, 4'b0011);
    done = 4'b0001;
    cycle(); drop_taken();
    done = '0;
    cycle(); drop_taken();
    check("tp_regrant", bus.cmd, 8'h42);
    cycle();

    // Round-robin back-to-back on disjoint endpoints
    do_reset();
    rq[0] = 8'h21; rv[0] = 1'b1;
    rq[1] = 8'h84; rv[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(); drop_taken();
    end

    // Back-pressure, then fill busy=1111 with a pending cmd and reset over it
    do_reset();
    ccr = 1'b0;
    rq[0] = 8'h21; rv[0] = 1'b1;
    rq[1] = 8'h84; rv[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(); drop_taken();
    end
    ccr = 1'b1;
    cycle(); drop_taken();
    ccr = 1'b0;
    cycle();
    check("tp_full", bus.busy, 4'b1111);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    ccr = 1'b1;
    done = 4'b0001;
    cycle();
    done = '0;
    cycle();

    // Illegal route 0 -> 1
    allow = '1;
    allow[1*N + 0] = 1'b0;
    do_reset();
    rq[0] = 8'h21; rv[0] = 1'b1;
    cycle(); drop_taken();
    cycle();
    cycle();
    allow = '1;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) begin
        allow = '1;
        if ($urandom_range(0, 1) == 1) allow = allow & ~(N*N)'($urandom & $urandom & $urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      for (int r = 0; r < R; r++) begin
        if (last_taken[r]) rv[r] = 1'b0;
        if (!rv[r] && $urandom_range(0, 2) == 0) begin
          rq[r] = rand_req();
          rv[r] = 1'b1;
        end
      end
      ccr = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        done[i] = (m_route[i] != 0 && $urandom_range(0, 4) == 0) || ($urandom_range(0, 29) == 0);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_switch_scheduler.md
Name: bus_switch_scheduler

Overview:
Schedules point-to-point route commands from R independent requesters onto the single cmd port of busSwitch. It avoids head-of-line blocking in the switch's one-entry command buffer by granting only requests whose endpoints are all idle. Grants are round-robin among eligible requesters. It tracks endpoint occupancy from per-source completion pulses and rejects malformed or disallowed routes.

Parameters:
N, 4, number of switch endpoints; same N as the busSwitch instance.
R, 2, number of requesters.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
req_cmd  input  R*2N  requester r occupies bits [r*2N +: 2N]; low N bits = source one-hot, high N bits = destination mask (busSwitch cmd format).
req_isReady  input  R  request r valid.
req_canReceive  output  R  request r consumed this cycle (granted or rejected).
allowedCMDMask  input  N*N  bit d*N+s set = route s->d legal; same mask as fed to busSwitch.
cmd  output  2N  command to busSwitch cmd.
cmd_isReady  output  1  cmd valid.
cmd_canReceive  input  1  busSwitch cmd_canReceive.
done_isLast  input  N  bit s pulses for one cycle when source s's last word handshakes (isLast & isReady & canReceive).
busy  output  N  registered endpoint-occupied mask.
err  output  1  one-cycle pulse: a request was rejected.
err_req  output  R  one-hot requester rejected with err; 0 otherwise.

Behaviour:
- Reset (rst=1 at clock edge): cmd_isReady=0, cmd=0, busy=0, route table=0, rr pointer=0, err=0, err_req=0. req_canReceive is combinational; it is 0 while rst=1.
- Handshake: a request is consumed when req_isReady[r] & req_canReceive[r]. req_canReceive may depend combinationally on req_isReady. Requesters must hold req_cmd stable until consumed.
- Malformed request: source field not exactly one-hot, destination field zero, source bit also set in destination, or any destination d with allowedCMDMask[d*N+s]=0.
  - A malformed request is rejected: consumed with err=1 and err_req one-hot in the next cycle.
  - No cmd is issued and busy is unchanged.
  - Rejection participates in round-robin like a grant, and at most one request is consumed per cycle.
- Eligible: req_isReady[r], well-formed, and (src|dst) & busy_reg == 0.
- Slot free: output register empty (cmd_isReady=0), or draining this cycle (cmd_isReady & cmd_canReceive).
- Selection: when the slot is free, the first eligible-or-malformed requester at or after the rr pointer, modulo R, is consumed. On consumption the rr pointer becomes index+1 mod R. If the slot is not free, nothing is consumed: req_canReceive=0 and the pointer is held.
- Grant in cycle t:
  - cmd <= req_cmd[r] and cmd_isReady <= 1 at t+1.
  - busy |= src|dst at t+1.
  - route[s] <= dst mask at t+1.
- Output hold: cmd and cmd_isReady are held stable until cmd_canReceive=1. They clear the cycle after acceptance unless a new grant refills them in the same cycle, giving back-to-back issue with no bubble.
- Release: done_isLast[s]=1 in cycle t clears busy[s], busy bits of route[s], and route[s] at t+1.
  - If done_isLast[s] arrives while busy[s]=0, it is ignored.
  - Multiple sources may release in the same cycle.
- Simultaneous grant and release: eligibility always uses the registered busy. An endpoint freed by a release at t is grantable no earlier than t+1. If a grant and a release touch different bits in the same cycle, both apply.
- Endpoint exclusivity: no endpoint ever belongs to two outstanding routes, so every issued cmd is accepted by busSwitch without waiting on its internal conflict check.
- Reset mid-operation: all outstanding routes are forgotten and busy clears. A pending cmd is dropped (cmd_isReady=0 next cycle).
- Latency: request to cmd_isReady is 1 cycle; release to re-grantable is 1 cycle.

Test Plan:
- N=4, R=2, all routes allowed. Req0 = src 0001, dst 0010 -> req_canReceive[0]=1 in cycle 0; cmd=0x21, cmd_isReady=1 in cycle 1; busy=0011.
- Conflict: req0 holds 0->1. Req1 asks 1->2 and is stalled while busy[1]=1. done_isLast=0001 at t -> busy=0000 at t+1; req1 granted at t+1; cmd=0x42 at t+2.
- Round-robin: req0 (0->1) and req1 (2->3) both pending, disjoint endpoints, pointer=0 -> req0 granted in cycle 0, req1 in cycle 1 with no bubble. cmd_canReceive held at 1 throughout.
- Back-pressure: cmd_canReceive=0 for 5 cycles -> cmd held constant and no further req_canReceive pulses. Release cmd_canReceive -> next grant in the same cycle.
- Illegal route: allowedCMDMask bit 1*4+0 cleared, req0 asks 0->1 -> consumed; err=1 and err_req=01 for one cycle; busy stays 0; cmd_isReady stays 0.
- Reset with busy=1111 and cmd pending -> next cycle busy=0, cmd_isReady=0. done_isLast=0001 then ignored.
